// File: rtl/cfg_frame_shift_loader.sv
// Serial config bitstream to BL frame register, then one-hot WL write strobe per row.
// Frames are shifted MSB first; WL_DEPTH frames make up one load.
module cfg_frame_shift_loader #(
  parameter int BL_WIDTH   = 8,
  parameter int WL_DEPTH   = 4,
  parameter int WEN_CYCLES = 2,
  localparam int RW = (WL_DEPTH > 1) ? $clog2(WL_DEPTH) : 1
) (
  input  logic                CK,
  input  logic                RSTN,
  input  logic                start,
  input  logic                abort,
  input  logic                din_valid,
  input  logic                din,
  output logic                din_ready,
  output logic [BL_WIDTH-1:0] bl,
  output logic [WL_DEPTH-1:0] wlw,
  output logic [RW-1:0]       row,
  output logic                busy,
  output logic                done
);

  localparam int BW = (BL_WIDTH > 1) ? $clog2(BL_WIDTH) : 1;
  localparam int CW = (WEN_CYCLES > 1) ? $clog2(WEN_CYCLES) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(BL_WIDTH - 1);
  localparam logic [CW-1:0] WEN_LAST = CW'(WEN_CYCLES - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(WL_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [BW-1:0]     bit_cnt;
  logic [CW-1:0]     wen_cnt;
  logic [BL_WIDTH-1:0] bl_shift;

  generate
    if (BL_WIDTH == 1) begin : g_one
      assign bl_shift = din;
    end else begin : g_many
      assign bl_shift = {bl[BL_WIDTH-2:0], din};
    end
  endgenerate

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start) state_n = SHIFT;
      SHIFT: if (din_valid && bit_cnt == BIT_LAST)
               state_n = WRITE;
      WRITE: if (wen_cnt == WEN_LAST)
               state_n = (row == ROW_LAST) ? DONE : SHIFT;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort) state_n = IDLE;
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state   <= IDLE;
      bl      <= '0;
      row     <= '0;
      bit_cnt <= '0;
      wen_cnt <= '0;
    end else begin
      state <= state_n;
      if (abort) begin
        row     <= '0;
        bit_cnt <= '0;
        wen_cnt <= '0;
      end else begin
        unique case (state)
          IDLE: if (start) begin
            row     <= '0;
            bit_cnt <= '0;
          end
          SHIFT: if (din_valid) begin
            bl      <= bl_shift;
            bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
          end
          WRITE: if (wen_cnt == WEN_LAST) begin
            wen_cnt <= '0;
            if (row != ROW_LAST) row <= row + RW'(1);
          end else begin
            wen_cnt <= wen_cnt + CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  // Strobe is a pure decode of registered state/row, so it can never be multi-hot
  always_comb begin
    wlw = '0;
    for (int i = 0; i < WL_DEPTH; i++)
      wlw[i] = (state == WRITE) && (row == RW'(i));
  end

  assign din_ready = (state == SHIFT);
  assign busy      = (state == SHIFT) || (state == WRITE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_cfg_frame_shift_loader.sv
// Directed bench for cfg_frame_shift_loader: default 8x4x2 instance
// plus a 1x1x1 corner instance.
module tb_cfg_frame_shift_loader;

  logic CK = 1'b0;
  logic RSTN;
  always #5 CK = ~CK;

  logic       start, abort, din_valid, din;
  logic       din_ready, busy, done;
  logic [7:0] bl;
  logic [3:0] wlw;
  logic [1:0] row;

  logic       c_start, c_abort, c_din_valid, c_din;
  logic       c_din_ready, c_busy, c_done;
  logic [0:0] c_bl, c_wlw, c_row;

  cfg_frame_shift_loader #(
    .BL_WIDTH(8), .WL_DEPTH(4), .WEN_CYCLES(2)
  ) dut (
    .CK(CK), .RSTN(RSTN), .start(start), .abort(abort),
    .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .bl(bl), .wlw(wlw), .row(row), .busy(busy), .done(done)
  );

  cfg_frame_shift_loader #(
    .BL_WIDTH(1), .WL_DEPTH(1), .WEN_CYCLES(1)
  ) dut_c (
    .CK(CK), .RSTN(RSTN), .start(c_start), .abort(c_abort),
    .din_valid(c_din_valid), .din(c_din), .din_ready(c_din_ready),
    .bl(c_bl), .wlw(c_wlw), .row(c_row), .busy(c_busy), .done(c_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // monitor: strobe log, done log, invariants
  logic [3:0] s_wlw[$];
  logic [7:0] s_bl[$];
  int         s_len[$];
  int cyc = 0, done_cnt = 0, done_cyc = 0, last_strobe = 0;
  int viol = 0, cviol = 0, bl_moved = 0;
  logic [3:0] prev_wlw = '0;

  always @(negedge CK) begin
    cyc <= cyc + 1;
    if (wlw != 4'b0) begin
      if (wlw != prev_wlw) begin
        s_wlw.push_back(wlw);
        s_bl.push_back(bl);
        s_len.push_back(1);
      end else begin
        s_len[s_len.size()-1] = s_len[s_len.size()-1] + 1;
        if (bl != s_bl[s_bl.size()-1]) bl_moved = bl_moved + 1;
      end
      last_strobe = cyc;
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if ($countones(wlw) > 1) viol = viol + 1;
    if (wlw != 4'b0 && prev_wlw != 4'b0 && wlw != prev_wlw) viol = viol + 1;
    if (din_ready && (!busy || wlw != 4'b0)) viol = viol + 1;
    if (c_din_ready && (!c_busy || c_wlw != 1'b0)) cviol = cviol + 1;
    prev_wlw = wlw;
  end

  task automatic tick;
    @(posedge CK);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] f, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      int n;
      din_valid = 1'b1;
      din = f[i];
      n = 0;
      while (!din_ready && n < 100) begin
        tick;
        n++;
      end
      if (n >= 100) chk("ready_timeout", 0, 1);
      tick;
      din_valid = 1'b0;
    end
  endtask

  task automatic wait_done;
    int n;
    n = 0;
    while (!done && n < 200) begin
      tick;
      n++;
    end
    if (n >= 200) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_load(input string tag, input int sb, input int db,
                          input logic [7:0] f[4]);
    chk({tag, "_nstrobe"}, s_wlw.size() - sb, 4);
    for (int r = 0; r < 4; r++) begin
      logic [3:0] ew, gw;
      logic [7:0] gb;
      int gl;
      ew = 4'b0001 << r;
      gw = '0; gb = '0; gl = 0;
      if (sb + r < s_wlw.size()) begin
        gw = s_wlw[sb+r];
        gb = s_bl[sb+r];
        gl = s_len[sb+r];
      end
      chk({tag, "_wlw"}, gw, ew);
      chk({tag, "_bl"}, gb, f[r]);
      chk({tag, "_len"}, gl, 2);
    end
    chk({tag, "_ndone"}, done_cnt - db, 1);
    chk({tag, "_done_lag"}, done_cyc - last_strobe, 1);
  endtask

  task automatic full_load(input logic [7:0] f[4]);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int r = 0; r < 4; r++) send_bits(f[r], 7, 0);
    wait_done;
    tick;
  endtask

  logic [7:0] fa[4], fb[4], fc[4];
  int sb, db;

  initial begin
    fa = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    fb = '{8'hA5, 8'h11, 8'h22, 8'h33};
    fc = '{8'h5A, 8'hC3, 8'h0F, 8'hF0};
    {start, abort, din_valid, din} = '0;
    {c_start, c_abort, c_din_valid, c_din} = '0;
    RSTN = 1'b0;
    repeat (3) @(posedge CK);
    #1;
    chk("rst_bl", bl, 0);
    chk("rst_wlw", wlw, 0);
    chk("rst_row", row, 0);
    chk("rst_ready", din_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_c_bl", c_bl, 0);
    RSTN = 1'b1;
    tick;

    // 1: contiguous load
    sb = s_wlw.size(); db = done_cnt;
    full_load(fa);
    chk_load("t1", sb, db, fa);
    chk("t1_row_hold", row, 3);
    chk("t1_idle_busy", busy, 0);

    // 2: din_valid gap mid-frame
    sb = s_wlw.size(); db = done_cnt;
    start = 1'b1;
    tick;
    start = 1'b0;
    send_bits(fb[0], 7, 4);
    repeat (5) tick;
    chk("t2_gap_busy", busy, 1);
    chk("t2_gap_wlw", wlw, 0);
    chk("t2_gap_ready", din_ready, 1);
    send_bits(fb[0], 3, 0);
    chk("t2_write_now", wlw, 4'b0001);
    chk("t2_bl", bl, 8'hA5);
    for (int r = 1; r < 4; r++) send_bits(fb[r], 7, 0);
    wait_done;
    tick;
    chk_load("t2", sb, db, fb);

    // 3: async reset in WRITE of row 2
    db = done_cnt;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int r = 0; r < 3; r++) send_bits(fc[r], 7, 0);
    chk("t3_in_row2", wlw, 4'b0100);
    RSTN = 1'b0;
    #1;
    chk("t3_async_wlw", wlw, 0);
    chk("t3_async_bl", bl, 0);
    chk("t3_async_row", row, 0);
    chk("t3_async_busy", busy, 0);
    @(posedge CK);
    #1;
    RSTN = 1'b1;
    repeat (20) tick;
    chk("t3_no_done", done_cnt - db, 0);
    sb = s_wlw.size(); db = done_cnt;
    full_load(fc);
    chk_load("t3", sb, db, fc);

    // 4a: abort in SHIFT of row 1
    db = done_cnt;
    start = 1'b1;
    tick;
    start = 1'b0;
    send_bits(8'hA5, 7, 0);
    send_bits(8'hC0, 7, 5);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("t4a_wlw", wlw, 0);
    chk("t4a_row", row, 0);
    chk("t4a_busy", busy, 0);
    chk("t4a_ready", din_ready, 0);
    chk("t4a_bl_kept", bl, 8'h2E);
    repeat (10) tick;
    chk("t4a_no_done", done_cnt - db, 0);
    sb = s_wlw.size(); db = done_cnt;
    full_load(fa);
    chk_load("t4a", sb, db, fa);

    // 4b: abort in WRITE of row 3
    db = done_cnt;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int r = 0; r < 4; r++) send_bits(fb[r], 7, 0);
    chk("t4b_in_row3", wlw, 4'b1000);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("t4b_wlw", wlw, 0);
    chk("t4b_row", row, 0);
    chk("t4b_busy", busy, 0);
    chk("t4b_done", done, 0);
    repeat (10) tick;
    chk("t4b_no_done", done_cnt - db, 0);
    sb = s_wlw.size(); db = done_cnt;
    full_load(fb);
    chk_load("t4b", sb, db, fb);

    // start+abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick;
    {start, abort} = '0;
    chk("sa_idle_busy", busy, 0);

    // 5: start ignored in SHIFT and DONE
    sb = s_wlw.size(); db = done_cnt;
    start = 1'b1;
    tick;
    send_bits(fc[0], 7, 7);
    start = 1'b0;
    send_bits(fc[0], 6, 0);
    for (int r = 1; r < 4; r++) send_bits(fc[r], 7, 0);
    wait_done;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("t5_after_done_busy", busy, 0);
    repeat (10) tick;
    chk("t5_no_second", busy, 0);
    chk_load("t5", sb, db, fc);

    // 6: corner 1x1x1
    chk("t6_idle_ready", c_din_ready, 0);
    c_start = 1'b1;
    tick;
    c_start = 1'b0;
    chk("t6_ready", c_din_ready, 1);
    c_din_valid = 1'b1;
    c_din = 1'b1;
    tick;
    c_din_valid = 1'b0;
    chk("t6_wlw", c_wlw, 1);
    chk("t6_bl", c_bl, 1);
    chk("t6_wr_ready", c_din_ready, 0);
    tick;
    chk("t6_wlw_off", c_wlw, 0);
    chk("t6_done", c_done, 1);
    chk("t6_done_busy", c_busy, 0);
    tick;
    chk("t6_done_end", c_done, 0);

    chk("bl_frozen", bl_moved, 0);
    chk("inv_main", viol, 0);
    chk("inv_corner", cviol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
